// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter unit for the fetch stage.
// Holds the PC, picks the next PC (jump > branch > pc+4), runs the
// IDLE/RUN/WAIT_STEP/HALTED control FSM and counts committed PC updates.
// Optional feature: define PC_TRACE_EN to add a circular trace buffer of the
// last TRACE_DEPTH committed (old) PCs; without it o_trace_pc reads zero.
module pc_sequencer #(
    parameter int unsigned NB_PC       = 32,
    parameter int unsigned RESET_PC    = 0,
    parameter int unsigned IMEM_BYTES  = 1024,
    parameter int unsigned TRACE_DEPTH = 8,
    localparam int unsigned TIDX_W     = $clog2(TRACE_DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_debug_mode,
    input  logic              i_step,
    input  logic              i_stall,
    input  logic              i_jump,
    input  logic [NB_PC-1:0]  i_jump_target,
    input  logic              i_branch_taken,
    input  logic [NB_PC-1:0]  i_branch_target,
    input  logic              i_halt_instr,
    input  logic [TIDX_W-1:0] i_trace_idx,
    output logic [NB_PC-1:0]  o_pc,
    output logic [NB_PC-1:0]  o_pc_4,
    output logic [NB_PC-1:0]  o_pc_8,
    output logic              o_fetch_en,
    output logic [1:0]        o_state,
    output logic              o_halted,
    output logic              o_misaligned,
    output logic [NB_PC-1:0]  o_instr_count,
    output logic [NB_PC-1:0]  o_trace_pc
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_RUN       = 2'b01,
        ST_WAIT_STEP = 2'b10,
        ST_HALTED    = 2'b11
    } state_t;

    localparam logic [NB_PC-1:0] RESET_PC_V = NB_PC'(RESET_PC);
    // One extra bit so an IMEM_BYTES equal to 2^NB_PC still compares correctly.
    localparam logic [NB_PC:0]   IMEM_LIMIT = (NB_PC + 1)'(IMEM_BYTES);

    state_t           state_q, state_d;
    logic [NB_PC-1:0] pc_q, pc_d;
    logic [NB_PC-1:0] cnt_q, cnt_d;
    logic             mis_q, mis_d;
    logic             step_q, step_d;

    logic             step_edge_s;
    logic             adv_s;
    logic             redir_s;
    logic [NB_PC-1:0] raw_target_s;
    logic [NB_PC-1:0] next_pc_s;
    logic             out_of_range_s;
    logic             halt_s;
    logic             commit_s;

    // Advance qualification and next-PC selection with redirect priority.
    always_comb begin
        step_edge_s = i_step & ~step_q;
        adv_s       = ~i_stall & ((state_q == ST_RUN) |
                                  ((state_q == ST_WAIT_STEP) & step_edge_s));
        if (i_jump) begin
            redir_s      = 1'b1;
            raw_target_s = i_jump_target;
        end else if (i_branch_taken) begin
            redir_s      = 1'b1;
            raw_target_s = i_branch_target;
        end else begin
            redir_s      = 1'b0;
            raw_target_s = pc_q + NB_PC'(4);
        end
        // Redirect targets are word-aligned by dropping the low two bits.
        if (redir_s) begin
            next_pc_s = {raw_target_s[NB_PC-1:2], 2'b00};
        end else begin
            next_pc_s = raw_target_s;
        end
        out_of_range_s = ({1'b0, next_pc_s} >= IMEM_LIMIT);
        halt_s         = adv_s & (i_halt_instr | out_of_range_s);
        commit_s       = adv_s & ~i_halt_instr & ~out_of_range_s;
    end

    // Next-state, PC, counter, sticky-flag and step-history computation.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        mis_d   = mis_q | (adv_s & redir_s & (raw_target_s[1:0] != 2'b00));
        step_d  = i_step;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = i_debug_mode ? ST_WAIT_STEP : ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN, ST_WAIT_STEP: begin
                if (halt_s) begin
                    state_d = ST_HALTED;
                end else begin
                    state_d = state_q;
                end
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
        endcase
        if (commit_s) begin
            pc_d = next_pc_s;
            if (cnt_q != {NB_PC{1'b1}}) begin
                cnt_d = cnt_q + NB_PC'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            pc_d  = pc_q;
            cnt_d = cnt_q;
        end
    end

    // Control/state registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC_V;
            cnt_q   <= {NB_PC{1'b0}};
            mis_q   <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
            step_q  <= step_d;
        end
    end

    assign o_pc          = pc_q;
    assign o_pc_4        = pc_q + NB_PC'(4);
    assign o_pc_8        = pc_q + NB_PC'(8);
    assign o_fetch_en    = adv_s;
    assign o_state       = state_q;
    assign o_halted      = (state_q == ST_HALTED);
    assign o_misaligned  = mis_q;
    assign o_instr_count = cnt_q;

`ifdef PC_TRACE_EN
    logic [NB_PC-1:0]  trace_q [TRACE_DEPTH];
    logic [NB_PC-1:0]  trace_d [TRACE_DEPTH];
    logic [TIDX_W-1:0] wptr_q, wptr_d;
    logic [TIDX_W-1:0] rd_idx_s;

    // Record the outgoing PC on every commit; pointer wraps at TRACE_DEPTH.
    always_comb begin
        trace_d = trace_q;
        wptr_d  = wptr_q;
        if (commit_s) begin
            trace_d[wptr_q] = pc_q;
            wptr_d          = wptr_q + TIDX_W'(1);
        end else begin
            wptr_d = wptr_q;
        end
    end

    // Trace storage and write pointer, cleared on reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wptr_q <= {TIDX_W{1'b0}};
            for (int i = 0; i < int'(TRACE_DEPTH); i++) begin
                trace_q[i] <= {NB_PC{1'b0}};
            end
        end else begin
            wptr_q  <= wptr_d;
            trace_q <= trace_d;
        end
    end

    // Index 0 is the most recent entry, counting backwards from the pointer.
    always_comb begin
        rd_idx_s   = wptr_q - TIDX_W'(1) - i_trace_idx;
        o_trace_pc = trace_q[rd_idx_s];
    end
`else
    logic unused_trace_s;
    assign unused_trace_s = ^i_trace_idx;
    assign o_trace_pc     = {NB_PC{1'b0}};
`endif

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program-counter unit for the fetch stage.
- Holds the PC and selects the next PC: jump target, branch target or sequential PC+4.
- Runs a run/debug-step/halt state machine driven by the debug unit, and counts committed instructions.
- Sits between the debug/UART control and instruction memory. It is the successor of the plain PC register and adds stall gating, redirect priority, step edge detection, halt handling and an optional PC trace buffer.

Parameters:
NB_PC, 32, PC and address width in bits
RESET_PC, 0, PC value loaded on reset
IMEM_BYTES, 1024, instruction memory size in bytes; a PC at or above this value is out of range
TRACE_DEPTH, 8, trace buffer entries; power of two, at least 2 (used only with PC_TRACE_EN)

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_start  in  1  leaves IDLE
i_debug_mode  in  1  sampled on i_start: 0 selects RUN, 1 selects WAIT_STEP
i_step  in  1  debug step request; level input, edge-detected internally
i_stall  in  1  hazard stall; blocks the PC update
i_jump  in  1  jump redirect
i_jump_target  in  NB_PC  jump target
i_branch_taken  in  1  branch redirect
i_branch_target  in  NB_PC  branch target
i_halt_instr  in  1  decode stage detected a HALT instruction
i_trace_idx  in  clog2(TRACE_DEPTH)  trace read index; 0 is the most recent entry
o_pc  out  NB_PC  current PC
o_pc_4  out  NB_PC  o_pc+4, modulo 2^NB_PC
o_pc_8  out  NB_PC  o_pc+8, link value for JAL
o_fetch_en  out  1  PC advances at the next clock edge (adv)
o_state  out  2  FSM state: 00 IDLE, 01 RUN, 10 WAIT_STEP, 11 HALTED
o_halted  out  1  high when state is HALTED
o_misaligned  out  1  sticky flag: a redirect target had bits [1:0] nonzero
o_instr_count  out  NB_PC  number of committed PC updates
o_trace_pc  out  NB_PC  trace buffer entry selected by i_trace_idx

Behaviour:
Reset
- Reset wins over all other inputs.
- Resulting values: pc=RESET_PC, state=IDLE, o_instr_count=0, o_misaligned=0, step edge register=0, trace pointer=0, all trace entries=0.
- Reset mid-step or mid-halt returns the block to IDLE.

Step edge and advance
- step_edge = i_step & ~step_q, where step_q is i_step registered.
- adv = ~i_stall & (state==RUN | (state==WAIT_STEP & step_edge)).
- o_fetch_en = adv, combinational.
- A step pulse that arrives while i_stall=1 is lost, not queued.

Next-PC selection (priority order)
- i_jump, then i_branch_taken, then pc+4.
- Redirect targets have bits [1:0] forced to 0. If the raw target had nonzero low bits, o_misaligned is set and stays set until reset.
- Redirects are ignored when adv=0.

Commit rules, evaluated when adv=1
- If i_halt_instr=1: PC unchanged, state goes to HALTED, no count increment, no trace write.
- Else if the selected next PC >= IMEM_BYTES: PC unchanged, state goes to HALTED, no count increment.
- Else: pc <= next PC, o_instr_count increments (saturates at all-ones), and the trace buffer records the old PC.

FSM
- IDLE: moves on i_start to RUN if i_debug_mode=0, else to WAIT_STEP. PC holds at RESET_PC.
- RUN: advances on every non-stalled cycle.
- WAIT_STEP: advances exactly once per rising edge of i_step.
- HALTED: absorbing state; all inputs except reset are ignored, o_fetch_en=0.
- i_start in any state other than IDLE is ignored.
- i_debug_mode changes after i_start have no effect.

Arithmetic and timing
- o_pc_4 and o_pc_8 wrap modulo 2^NB_PC.
- Update latency: the new PC is visible on o_pc one cycle after the edge where adv=1.

Optional Feature:
Macro: PC_TRACE_EN
- Defined: circular buffer of TRACE_DEPTH entries. On each commit, the old PC is written at the write pointer and the pointer increments, wrapping at TRACE_DEPTH. o_trace_pc is a combinational read of entry (wptr-1-i_trace_idx) mod TRACE_DEPTH. Entries not yet written read 0.
- Not defined: no buffer storage; o_trace_pc is tied to 0. All other behaviour is identical.

Test Plan:
1. Reset, then i_start with i_debug_mode=0, no stall for 4 cycles -> o_pc steps 0,4,8,12,16; o_instr_count=4; o_state=01.
2. RUN at pc=8; same cycle i_jump=1 (target 0x40) and i_branch_taken=1 (target 0x80) -> o_pc=0x40 next cycle. Then branch target 0x83 -> o_pc=0x80 and o_misaligned=1.
3. Debug mode: hold i_step high 5 cycles -> o_pc advances 0->4 only. Drop, then raise again -> o_pc=8. Raise i_step while i_stall=1 -> o_pc stays 8.
4. IMEM_BYTES=16, RUN from 0 -> o_pc reaches 12, then state=HALTED, o_pc stays 12, o_instr_count=3. Further i_start and i_step have no effect.
5. RUN, assert i_halt_instr at pc=8 -> HALTED, o_pc=8, o_fetch_en=0. Then i_reset -> o_pc=RESET_PC, o_state=00, o_instr_count=0.
6. With PC_TRACE_EN and TRACE_DEPTH=4, run 6 commits from 0 -> i_trace_idx 0..3 reads 20,16,12,8. Without the macro -> o_trace_pc=0.
